// File: rtl/toeplitz_row_sched.sv
// toeplitz_row_sched: sequences memory fetches, Toeplitz row shifting and accumulator strobes for one hash run.
module toeplitz_row_sched #(
  parameter int unsigned ROW_W      = 3072,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned N_WORDS    = 128,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned COEFF_BASE = 0,
  parameter int unsigned SEED_BASE  = 128
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [ROW_W-1:0]  row_out,
  output logic              acc_clr,
  output logic              acc_xor,
  output logic              busy,
  output logic              done
);
  localparam int unsigned RW = ROW_W / WORD_W;
  localparam int unsigned KW = $clog2(N_WORDS) + 1;
  localparam int unsigned JW = $clog2(WORD_W);
  localparam int unsigned LW = $clog2(RW + 1) + 1;
  localparam logic [ADDR_W-1:0] COEFF_A = ADDR_W'(COEFF_BASE);
  localparam logic [ADDR_W-1:0] SEED_A = ADDR_W'(SEED_BASE);
  localparam logic [ADDR_W-1:0] SEED_RW_A = ADDR_W'(SEED_BASE + RW);
  typedef enum logic [2:0] {IDLE, LOAD, FETCH_C, FETCH_S, WAIT_S, PROC, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lc_q, lc_d;
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic [WORD_W-1:0] coeff_q, coeff_d, seed_q, seed_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q;
  always_comb begin
    state_d = state_q;
    lc_d = lc_q;
    k_d = k_q;
    j_d = j_q;
    coeff_d = coeff_q;
    seed_d = seed_q;
    row_d = row_q;
    mem_rd_en = 1'b0;
    mem_addr = addr_q;
    acc_clr = 1'b0;
    acc_xor = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        lc_d = '0;
      end
      LOAD: begin
        // Reads lead captures by one cycle, so LOAD spans RW+1 cycles.
        acc_clr = (lc_q == '0);
        mem_rd_en = (lc_q != LW'(RW));
        mem_addr = mem_rd_en ? SEED_A + ADDR_W'(lc_q) : addr_q;
        row_d = (lc_q != '0) ? ROW_W'({row_q, mem_rdata}) : row_q;
        lc_d = lc_q + 1'b1;
        if (lc_q == LW'(RW)) begin
          state_d = FETCH_C;
          k_d = '0;
        end
      end
      FETCH_C: begin
        mem_rd_en = 1'b1;
        mem_addr = COEFF_A + ADDR_W'(k_q);
        state_d = FETCH_S;
      end
      FETCH_S: begin
        mem_rd_en = 1'b1;
        mem_addr = SEED_RW_A + ADDR_W'(k_q);
        coeff_d = mem_rdata;
        state_d = WAIT_S;
      end
      WAIT_S: begin
        seed_d = mem_rdata;
        j_d = '0;
        state_d = PROC;
      end
      PROC: begin
        acc_xor = coeff_q[WORD_W-1];
        row_d = {row_q[ROW_W-2:0], seed_q[WORD_W-1]};
        coeff_d = coeff_q << 1;
        seed_d = seed_q << 1;
        j_d = j_q + 1'b1;
        if (j_q == JW'(WORD_W - 1)) begin
          k_d = k_q + 1'b1;
          state_d = (k_q == KW'(N_WORDS - 1)) ? DONE : FETCH_C;
        end
      end
      DONE: begin
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lc_q <= '0;
      k_q <= '0;
      j_q <= '0;
      coeff_q <= '0;
      seed_q <= '0;
      row_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      lc_q <= lc_d;
      k_q <= k_d;
      j_q <= j_d;
      coeff_q <= coeff_d;
      seed_q <= seed_d;
      row_q <= row_d;
      addr_q <= mem_addr;
    end
  end
  assign row_out = row_q;
  assign busy = (state_q != IDLE);
endmodule
